// File: rtl/axby_if_ctrl.sv
// axby_if_ctrl
// Host-interface sequencer for the AX+BY datapath. Loads NOPS operand
// registers via one-hot PL pulses, runs the core (START) until its done flag
// SETRDYP arrives (optionally guarded by a TMO-cycle watchdog), then steps a
// one-hot OE across the NOUT result words, most-significant word first.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   WR / RD      host write / read strobes (levels)
//   SETRDYP      core done flag (level)
//   ABORT        synchronous return to IDLE from any state
//   PL           one-hot operand load pulse (PL[i] loads operand i)
//   START        core run enable, high from RUN through RDEND
//   RDYP         result ready to the host
//   OE           one-hot result output enable (OE[NOUT-1] is the MS word)
//   WIDX / RIDX  operands loaded / result words read so far
//   ERR          watchdog expired
//   dbg_state_o  registered FSM state, for checkers and debug
//
// Handshake: WR and RD are level strobes. A strobe is accepted on the rising
// edge where it is sampled high in a state that listens for it; each accepted
// assertion produces exactly one transfer (one PL pulse, or one OE window),
// and the next transfer needs the strobe to be sampled low then high again.
// Strobes sampled in states that do not listen for them are ignored.

module axby_if_ctrl #(
  parameter int NOPS = 2,
  parameter int NOUT = 2,
  parameter int TMO  = 0,
  localparam int WW  = $clog2(NOPS) + 1,
  localparam int RW  = $clog2(NOUT) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            WR,
  input  logic            RD,
  input  logic            SETRDYP,
  input  logic            ABORT,
  output logic [NOPS-1:0] PL,
  output logic            START,
  output logic            RDYP,
  output logic [NOUT-1:0] OE,
  output logic [WW-1:0]   WIDX,
  output logic [RW-1:0]   RIDX,
  output logic            ERR,
  output logic [3:0]      dbg_state_o
);

  // tc must still be at least one bit wide when the watchdog is disabled.
  localparam int TCW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [TCW-1:0] TC_LAST = (TMO > 0) ? TCW'(TMO - 1) : '0;
  localparam logic [TCW-1:0] TC_MAX  = {TCW{1'b1}};
  localparam bit WD_EN = (TMO > 0);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_LHOLD = 4'd2,
    S_LWAIT = 4'd3,
    S_RUN   = 4'd4,
    S_RWAIT = 4'd5,
    S_RDOUT = 4'd6,
    S_RDEND = 4'd7,
    S_FAULT = 4'd8
  } state_e;

  state_e         state_q, state_d;
  logic [WW-1:0]  wi_q, wi_d;
  logic [RW-1:0]  ri_q, ri_d;
  logic [TCW-1:0] tc_q, tc_d;

  logic [WW-1:0]  wi_inc;
  logic [RW-1:0]  ri_inc;

  // Index counters stop at their limits rather than wrapping.
  assign wi_inc = (wi_q == WW'(NOPS)) ? wi_q : wi_q + WW'(1);
  assign ri_inc = (ri_q == RW'(NOUT)) ? ri_q : ri_q + RW'(1);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    ri_d    = ri_q;
    tc_d    = tc_q;
    case (state_q)
      S_IDLE: begin
        wi_d = '0;
        ri_d = '0;
        tc_d = '0;
        if (WR) state_d = S_LOAD;
      end
      S_LOAD: begin
        wi_d = wi_inc;
        if (WR) begin
          state_d = S_LHOLD;
        end else if (wi_inc == WW'(NOPS)) begin
          // Last operand written with a short strobe: skip LWAIT.
          state_d = S_RUN;
          tc_d    = '0;
        end else begin
          state_d = S_LWAIT;
        end
      end
      S_LHOLD: begin
        if (!WR) begin
          if (wi_q == WW'(NOPS)) begin
            state_d = S_RUN;
            tc_d    = '0;
          end else begin
            state_d = S_LWAIT;
          end
        end
      end
      S_LWAIT: begin
        if (WR) state_d = S_LOAD;
      end
      S_RUN: begin
        // Done flag wins over a watchdog expiry in the same cycle.
        if (SETRDYP) begin
          state_d = S_RWAIT;
        end else if (WD_EN && (tc_q == TC_LAST)) begin
          state_d = S_FAULT;
          wi_d    = '0;
          ri_d    = '0;
        end else if (tc_q != TC_MAX) begin
          tc_d = tc_q + TCW'(1);
        end
      end
      S_RWAIT: begin
        if (RD) state_d = S_RDOUT;
      end
      S_RDOUT: begin
        if (!RD) begin
          ri_d    = ri_inc;
          state_d = (ri_inc == RW'(NOUT)) ? S_RDEND : S_RWAIT;
        end
      end
      S_RDEND: begin
        state_d = S_IDLE;
        wi_d    = '0;
        ri_d    = '0;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
        wi_d    = '0;
        ri_d    = '0;
        tc_d    = '0;
      end
    endcase

    if (ABORT) begin
      state_d = S_IDLE;
      wi_d    = '0;
      ri_d    = '0;
      tc_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wi_q    <= '0;
      ri_q    <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      ri_q    <= ri_d;
      tc_q    <= tc_d;
    end
  end

  // Moore output decode from registered state and counters only.
  always_comb begin
    PL    = '0;
    OE    = '0;
    START = 1'b0;
    RDYP  = 1'b0;
    ERR   = 1'b0;
    for (int i = 0; i < NOPS; i++) begin
      PL[i] = (state_q == S_LOAD) && (wi_q == WW'(i));
    end
    // OE bit j is the word read when ri == NOUT-1-j, giving MS word first.
    for (int j = 0; j < NOUT; j++) begin
      OE[j] = (state_q == S_RDOUT) && (ri_q == RW'(NOUT - 1 - j));
    end
    START = (state_q inside {S_RUN, S_RWAIT, S_RDOUT, S_RDEND});
    RDYP  = (state_q inside {S_RWAIT, S_RDOUT, S_RDEND});
    ERR   = (state_q == S_FAULT);
  end

  assign WIDX        = wi_q;
  assign RIDX        = ri_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axby_if_ctrl.sv
// Testbench for axby_if_ctrl. Instance 0: NOPS=2 NOUT=2 TMO=0.
// Instance 1: NOPS=3 NOUT=4 TMO=10. Output events (PL pulses, OE changes,
// START/RDYP/ERR changes) are tagged with the cycle they appear in and
// compared against expectations pushed by the driver tasks.

module tb_axby_if_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic wr_s [2];
  logic rd_s [2];
  logic sr_s [2];
  logic ab_s [2];

  logic [1:0] pl_a, oe_a, widx_a, ridx_a;
  logic [2:0] pl_b, widx_b, ridx_b;
  logic [3:0] oe_b;
  logic       start_a, rdyp_a, err_a, start_b, rdyp_b, err_b;
  logic [3:0] dbg_a, dbg_b;

  logic [7:0] pl_v [2];
  logic [7:0] oe_v [2];
  logic [7:0] widx_v [2];
  logic [7:0] ridx_v [2];
  logic       start_v [2];
  logic       rdyp_v [2];
  logic       err_v [2];

  assign pl_v[0]   = {6'd0, pl_a};
  assign pl_v[1]   = {5'd0, pl_b};
  assign oe_v[0]   = {6'd0, oe_a};
  assign oe_v[1]   = {4'd0, oe_b};
  assign widx_v[0] = {6'd0, widx_a};
  assign widx_v[1] = {5'd0, widx_b};
  assign ridx_v[0] = {6'd0, ridx_a};
  assign ridx_v[1] = {5'd0, ridx_b};
  assign start_v[0] = start_a;
  assign start_v[1] = start_b;
  assign rdyp_v[0]  = rdyp_a;
  assign rdyp_v[1]  = rdyp_b;
  assign err_v[0]   = err_a;
  assign err_v[1]   = err_b;

  axby_if_ctrl #(.NOPS(2), .NOUT(2), .TMO(0)) u_a (
    .clk(clk), .reset(reset), .WR(wr_s[0]), .RD(rd_s[0]),
    .SETRDYP(sr_s[0]), .ABORT(ab_s[0]), .PL(pl_a), .START(start_a),
    .RDYP(rdyp_a), .OE(oe_a), .WIDX(widx_a), .RIDX(ridx_a), .ERR(err_a),
    .dbg_state_o(dbg_a)
  );

  axby_if_ctrl #(.NOPS(3), .NOUT(4), .TMO(10)) u_b (
    .clk(clk), .reset(reset), .WR(wr_s[1]), .RD(rd_s[1]),
    .SETRDYP(sr_s[1]), .ABORT(ab_s[1]), .PL(pl_b), .START(start_b),
    .RDYP(rdyp_b), .OE(oe_b), .WIDX(widx_b), .RIDX(ridx_b), .ERR(err_b),
    .dbg_state_o(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  // Event word: kind(4) value(8) index(4) cycle(16).
  // kind 1 PL pulse, 2 OE change, 3 START change, 4 RDYP change, 5 ERR change.
  function automatic logic [31:0] ev(input int kind, input int val, input int idx, input int c);
    return {4'(kind), 8'(val), 4'(idx), 16'(c)};
  endfunction

  function automatic int nout_of(input int n);
    return (n == 0) ? 2 : 4;
  endfunction

  task automatic push(input int n, input logic [31:0] e);
    if (n == 0) exp_q_a.push_back(e);
    else        exp_q_b.push_back(e);
  endtask

  task automatic observe(input int n, input logic [31:0] act);
    logic [31:0] exp;
    int sz;
    checks++;
    sz = (n == 0) ? exp_q_a.size() : exp_q_b.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL event_u%0d got %h expected none (kind/val/idx/cyc)", n, act);
    end else begin
      exp = (n == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL event_u%0d got %h expected %h (kind/val/idx/cyc)", n, act, exp);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] oe_prev [2];
  logic       start_prev [2];
  logic       rdyp_prev [2];
  logic       err_prev [2];

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (mon_en) begin
        if (pl_v[n] != 8'd0)
          observe(n, ev(1, int'(pl_v[n]), int'(widx_v[n]), cyc));
        if (oe_v[n] != oe_prev[n])
          observe(n, ev(2, int'(oe_v[n]), int'(ridx_v[n]), cyc));
        if (start_v[n] != start_prev[n])
          observe(n, ev(3, int'(start_v[n]), 0, cyc));
        if (rdyp_v[n] != rdyp_prev[n])
          observe(n, ev(4, int'(rdyp_v[n]), 0, cyc));
        if (err_v[n] != err_prev[n])
          observe(n, ev(5, int'(err_v[n]), 0, cyc));
      end
      oe_prev[n]    = oe_v[n];
      start_prev[n] = start_v[n];
      rdyp_prev[n]  = rdyp_v[n];
      err_prev[n]   = err_v[n];
    end
  end

  // ---------------- direct checks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input int n, input string name);
    logic [7:0] any;
    any = pl_v[n] | oe_v[n] | widx_v[n] | ridx_v[n] |
          {7'd0, start_v[n]} | {7'd0, rdyp_v[n]} | {7'd0, err_v[n]};
    chk(name, int'(any), 0);
  endtask

  // ---------------- drivers ----------------
  // Write operand k with WR held for len cycles, then one idle cycle.
  task automatic wr_op(input int n, input int k, input int len, input bit last);
    int c0;
    c0 = cyc;
    push(n, ev(1, 1 << k, k, c0 + 1));
    wr_s[n] = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 1) chk("widx_hold", int'(widx_v[n]), k + 1);
    end
    wr_s[n] = 1'b0;
    if (last) push(n, ev(3, 1, 0, c0 + len + 1));
    @(negedge clk);
  endtask

  task automatic done_op(input int n);
    push(n, ev(4, 1, 0, cyc + 1));
    sr_s[n] = 1'b1;
    @(negedge clk);
    sr_s[n] = 1'b0;
  endtask

  // Read word k with RD held for len cycles.
  task automatic rd_op(input int n, input int k, input int len, input bit last);
    int c0;
    c0 = cyc;
    push(n, ev(2, 1 << (nout_of(n) - 1 - k), k, c0 + 1));
    rd_s[n] = 1'b1;
    repeat (len) @(negedge clk);
    rd_s[n] = 1'b0;
    push(n, ev(2, 0, k + 1, c0 + len + 1));
    if (last) begin
      push(n, ev(3, 0, 0, c0 + len + 2));
      push(n, ev(4, 0, 0, c0 + len + 2));
    end
    @(negedge clk);
    if (last) begin
      chk("ridx_full", int'(ridx_v[n]), nout_of(n));
      @(negedge clk);
      chk_idle(n, "idle_after_read");
    end
  endtask

  task automatic load_b();
    wr_op(1, 0, 1, 1'b0);
    wr_op(1, 1, 2, 1'b0);
    wr_op(1, 2, 1, 1'b1);
  endtask

  task automatic read_all_b();
    rd_op(1, 0, 1, 1'b0);
    rd_op(1, 1, 3, 1'b0);
    rd_op(1, 2, 1, 1'b0);
    rd_op(1, 3, 2, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int s;
    for (int n = 0; n < 2; n++) begin
      wr_s[n] = 1'b0; rd_s[n] = 1'b0; sr_s[n] = 1'b0; ab_s[n] = 1'b0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle(0, "reset_u0");
    chk_idle(1, "reset_u1");
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // u0: basic sequence, single-cycle strobes
    wr_op(0, 0, 1, 1'b0);
    wr_op(0, 1, 1, 1'b1);
    done_op(0);
    rd_op(0, 0, 1, 1'b0);
    rd_op(0, 1, 1, 1'b1);

    // u0: long WR on first operand, held strobes elsewhere
    wr_op(0, 0, 5, 1'b0);
    wr_op(0, 1, 2, 1'b1);
    done_op(0);
    rd_op(0, 0, 2, 1'b0);
    rd_op(0, 1, 1, 1'b1);

    // u0: ABORT in RWAIT beats a simultaneous RD
    wr_op(0, 0, 1, 1'b0);
    wr_op(0, 1, 1, 1'b1);
    done_op(0);
    c = cyc;
    push(0, ev(3, 0, 0, c + 1));
    push(0, ev(4, 0, 0, c + 1));
    ab_s[0] = 1'b1;
    rd_s[0] = 1'b1;
    @(negedge clk);
    ab_s[0] = 1'b0;
    rd_s[0] = 1'b0;
    chk_idle(0, "abort_u0");
    @(negedge clk);

    // u0: no watchdog; WR/RD ignored while running
    wr_op(0, 0, 1, 1'b0);
    wr_op(0, 1, 1, 1'b1);
    wr_s[0] = 1'b1;
    rd_s[0] = 1'b1;
    repeat (3) @(negedge clk);
    wr_s[0] = 1'b0;
    rd_s[0] = 1'b0;
    repeat (37) @(negedge clk);
    chk("run_no_wd_start", int'(start_v[0]), 1);
    chk("run_no_wd_err", int'(err_v[0]), 0);
    done_op(0);
    rd_op(0, 0, 1, 1'b0);
    rd_op(0, 1, 1, 1'b1);

    // u1: done on the last watchdog cycle (tc = TMO-1)
    load_b();
    repeat (9) @(negedge clk);
    done_op(1);
    chk("boundary_err", int'(err_v[1]), 0);
    read_all_b();

    // u1: done at tc = 8, then reset during RDOUT
    load_b();
    repeat (8) @(negedge clk);
    done_op(1);
    rd_op(1, 0, 1, 1'b0);
    c = cyc;
    push(1, ev(2, 4, 1, c + 1));
    rd_s[1] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_s[1] = 1'b0;
    push(1, ev(2, 0, 0, c + 2));
    push(1, ev(3, 0, 0, c + 2));
    push(1, ev(4, 0, 0, c + 2));
    @(negedge clk);
    reset = 1'b1;
    chk("reset_widx", int'(widx_v[1]), 0);
    chk("reset_ridx", int'(ridx_v[1]), 0);
    chk_idle(1, "reset_mid_u1");

    // u1: fresh complete sequence after reset
    load_b();
    done_op(1);
    read_all_b();

    // u1: watchdog expiry, inputs ignored in FAULT, ABORT recovery
    load_b();
    s = cyc;
    push(1, ev(3, 0, 0, s + 10));
    push(1, ev(5, 1, 0, s + 10));
    repeat (12) @(negedge clk);
    chk("fault_err", int'(err_v[1]), 1);
    chk("fault_start", int'(start_v[1]), 0);
    chk("fault_widx", int'(widx_v[1]), 0);
    wr_s[1] = 1'b1;
    rd_s[1] = 1'b1;
    sr_s[1] = 1'b1;
    repeat (2) @(negedge clk);
    wr_s[1] = 1'b0;
    rd_s[1] = 1'b0;
    sr_s[1] = 1'b0;
    @(negedge clk);
    chk("fault_held", int'(err_v[1]), 1);
    c = cyc;
    push(1, ev(5, 0, 0, c + 1));
    ab_s[1] = 1'b1;
    @(negedge clk);
    ab_s[1] = 1'b0;
    chk_idle(1, "abort_u1");

    repeat (5) @(negedge clk);
    chk("leftover_u0", exp_q_a.size(), 0);
    chk("leftover_u1", exp_q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
